// File: rtl/acc_sequencer_8bits_if.sv
// Command handshake and adder pin bundle for acc_sequencer_8bits.
// master = command issuer / adder side, slave = the sequencer itself.
interface acc_sequencer_8bits_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_sl;
    logic [WIDTH-1:0] add_so;
    logic             add_ovf;

    modport master (
        output start, op, operand, add_so, add_ovf,
        input  busy, done, add_a, add_b, add_sl
    );

    modport slave (
        input  start, op, operand, add_so, add_ovf,
        output busy, done, add_a, add_b, add_sl
    );
endinterface

// File: rtl/acc_sequencer_8bits.sv
// Accumulator and command sequencer (LOAD/ADD/SUB/MUL) driving an external 8-bit adder.
// Optional saturation on adder overflow: define ACC_SAT_EN.
module acc_sequencer_8bits #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] ACC_RST = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_ovf,
    acc_sequencer_8bits_if.slave bus,
    output logic [WIDTH-1:0]     acc,
    output logic                 ovf_flag
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    localparam logic [1:0]       OP_LOAD = 2'b00;
    localparam logic [1:0]       OP_ADD  = 2'b01;
    localparam logic [1:0]       OP_SUB  = 2'b10;
    localparam logic [1:0]       OP_MUL  = 2'b11;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic             ovf_q, ovf_d;
    logic             set_ovf;
    logic [WIDTH-1:0] commit_val;

`ifdef ACC_SAT_EN
    // On overflow both operands share add_a's sign, so it picks the rail.
    always_comb begin
        if (bus.add_ovf)
            commit_val = bus.add_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
        else
            commit_val = bus.add_so;
    end
`else
    assign commit_val = bus.add_so;
`endif

    // Adder pins kept in their own process so the external combinational
    // path add_a -> add_so never loops back through the next-state logic.
    always_comb begin
        bus.add_a  = acc_q;
        bus.add_b  = '0;
        bus.add_sl = 1'b0;
        if (state_q == EXEC && (op_q == OP_ADD || op_q == OP_SUB)) begin
            bus.add_b  = operand_q;
            bus.add_sl = (op_q == OP_SUB);
        end else if (state_q == MUL) begin
            bus.add_a = partial_q;
            bus.add_b = mcand_q;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        operand_d = operand_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        partial_d = partial_q;
        set_ovf   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    operand_d = bus.operand;
                    if (bus.op == OP_MUL) begin
                        mcand_d   = acc_q;
                        cnt_d     = bus.operand;
                        partial_d = '0;
                        state_d   = MUL;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (op_q == OP_LOAD) begin
                    acc_d = operand_q;
                end else if (op_q == OP_ADD || op_q == OP_SUB) begin
                    acc_d   = commit_val;
                    set_ovf = bus.add_ovf;
                end
                state_d = DONE;
            end
            MUL: begin
                if (cnt_q != '0) begin
                    partial_d = commit_val;
                    cnt_d     = cnt_q - ONE;
                    set_ovf   = bus.add_ovf;
                end else begin
                    acc_d   = partial_q;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A fresh overflow beats a simultaneous clear.
        ovf_d = set_ovf | (ovf_q & ~clr_ovf);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            acc_q     <= ACC_RST;
            operand_q <= '0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            partial_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            operand_q <= operand_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            partial_q <= partial_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy = (state_q == EXEC) || (state_q == MUL);
    assign bus.done = (state_q == DONE);
    assign acc      = acc_q;
    assign ovf_flag = ovf_q;
endmodule
